red_blob_tracker: RTL

Avalon-ST video sink that consumes the 320x240 RGB444 pixel stream produced by the frame-buffer address generator (sop/eop/valid/ready framing, the same stream the VGA scaler sink accepts). It classifies each accepted pixel as red or not and accumulates a per-frame red-pixel count and bounding box. At each well-formed end of frame it publishes registered results for the waiter's steering logic. It sits in parallel with the VGA path, in the 25 MHz VGA clock domain.

---
 rtl/video_pkg.sv | 22 ++
 rtl/red_blob_tracker_if.sv | 13 +
 rtl/red_pixel_classifier.sv | 20 ++
 rtl/red_blob_tracker.sv | 139 +++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video-stream types and sizing for the 320x240 RGB444 pixel path.
package video_pkg;

    localparam int DEF_FRAME_W = 320;
    localparam int DEF_FRAME_H = 240;
    localparam int X_W         = 9;
    localparam int Y_W         = 8;
    localparam int CNT_W       = 17;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PUBLISH = 2'd2
    } tracker_state_t;

endpackage

// File: rtl/red_blob_tracker_if.sv
// Avalon-ST pixel stream with sop/eop framing, as produced by the frame-buffer address generator.
interface red_blob_tracker_if;

    logic [11:0] snk_data;
    logic        snk_valid;
    logic        snk_sop;
    logic        snk_eop;
    logic        snk_ready;

    modport master (output snk_data, snk_valid, snk_sop, snk_eop, input snk_ready);
    modport slave  (input snk_data, snk_valid, snk_sop, snk_eop, output snk_ready);

endinterface

// File: rtl/red_pixel_classifier.sv
// Combinational red-dominance test shared with the VGA overlay.
module red_pixel_classifier
    import video_pkg::*;
(
    input  rgb444_t    pix,
    input  logic [3:0] margin,
    output logic       is_red
);

    logic [4:0] g_th;
    logic [4:0] b_th;

    // 5-bit thresholds so G/B plus margin can never wrap
    always_comb begin
        g_th   = {1'b0, pix.g} + {1'b0, margin};
        b_th   = {1'b0, pix.b} + {1'b0, margin};
        is_red = ({1'b0, pix.r} >= g_th) && ({1'b0, pix.r} >= b_th);
    end

endmodule

// File: rtl/red_blob_tracker.sv
// Per-frame red-pixel count and bounding box over an Avalon-ST video stream.
module red_blob_tracker
    import video_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H
) (
    input  logic               clk,
    input  logic               reset_n,
    red_blob_tracker_if.slave  snk,
    input  logic [3:0]         margin,
    output logic               frame_done,
    output logic               frame_error,
    output logic [CNT_W-1:0]   red_count,
    output logic               blob_found,
    output logic [X_W-1:0]     min_x,
    output logic [X_W-1:0]     max_x,
    output logic [Y_W-1:0]     min_y,
    output logic [Y_W-1:0]     max_y
);

    localparam logic [X_W-1:0] X_LAST = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_H - 1);

    tracker_state_t   state_q, state_nxt;
    logic             ready_q, err_q;
    rgb444_t          pix;
    logic             is_red, beat, is_last, frame_err, publish;
    logic [X_W-1:0]   x_q, cur_x, x_nxt;
    logic [Y_W-1:0]   y_q, cur_y, y_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [X_W-1:0]   min_x_q, max_x_q, min_x_nxt, max_x_nxt;
    logic [Y_W-1:0]   min_y_q, max_y_q, min_y_nxt, max_y_nxt;

    assign pix = snk.snk_data;

    red_pixel_classifier u_classifier (
        .pix    (pix),
        .margin (margin),
        .is_red (is_red)
    );

    // A frame beat is any accepted beat inside a frame, or an sop that (re)starts one
    always_comb begin
        beat      = snk.snk_valid && ready_q && ((state_q == ST_RUN) || snk.snk_sop);
        cur_x     = snk.snk_sop ? '0 : x_q;
        cur_y     = snk.snk_sop ? '0 : y_q;
        is_last   = (cur_x == X_LAST) && (cur_y == Y_LAST);
        frame_err = beat && (((state_q == ST_RUN) && snk.snk_sop) || (snk.snk_eop != is_last));
        publish   = beat && snk.snk_eop && is_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ready_q <= (state_nxt != ST_PUBLISH);
            err_q   <= frame_err;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (beat) begin
                    if (publish)                        state_nxt = ST_PUBLISH;
                    else if (snk.snk_eop || is_last)    state_nxt = ST_IDLE;
                    else                                state_nxt = ST_RUN;
                end
            end
            ST_PUBLISH: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign snk.snk_ready = ready_q;
    assign frame_done    = (state_q == ST_PUBLISH);
    assign frame_error   = err_q;

    // Next accumulator values include the current beat so the final pixel lands in the published result
    always_comb begin
        x_nxt     = (cur_x == X_LAST) ? '0 : cur_x + 1'b1;
        y_nxt     = (cur_x == X_LAST) ? cur_y + 1'b1 : cur_y;
        cnt_nxt   = snk.snk_sop ? '0 : cnt_q;
        min_x_nxt = snk.snk_sop ? '0 : min_x_q;
        max_x_nxt = snk.snk_sop ? '0 : max_x_q;
        min_y_nxt = snk.snk_sop ? '0 : min_y_q;
        max_y_nxt = snk.snk_sop ? '0 : max_y_q;
        if (is_red) begin
            if (cnt_nxt == '0) begin
                min_x_nxt = cur_x;
                max_x_nxt = cur_x;
                min_y_nxt = cur_y;
                max_y_nxt = cur_y;
            end else begin
                if (cur_x < min_x_nxt) min_x_nxt = cur_x;
                if (cur_x > max_x_nxt) max_x_nxt = cur_x;
                if (cur_y < min_y_nxt) min_y_nxt = cur_y;
                if (cur_y > max_y_nxt) max_y_nxt = cur_y;
            end
            cnt_nxt = cnt_nxt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            cnt_q   <= cnt_nxt;
            min_x_q <= min_x_nxt;
            max_x_q <= max_x_nxt;
            min_y_q <= min_y_nxt;
            max_y_q <= max_y_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            red_count  <= '0;
            blob_found <= 1'b0;
            min_x      <= '0;
            max_x      <= '0;
            min_y      <= '0;
            max_y      <= '0;
        end else if (publish) begin
            red_count  <= cnt_nxt;
            blob_found <= (cnt_nxt != '0);
            min_x      <= min_x_nxt;
            max_x      <= max_x_nxt;
            min_y      <= min_y_nxt;
            max_y      <= max_y_nxt;
        end
    end

endmodule
